// File: rtl/top_chip_test_monitor_pkg.sv
// ----------------------------------------------------------------------------
// top_chip_test_monitor_pkg
// Shared types and constants for the end-of-test monitor.
//   mon_state_e  : monitor FSM states
//   mon_result_e : outcome selected by the priority encoder on a detection edge
//   DefaultPassCode / DefaultFailCode : status words software writes at the end
//   sat_inc32    : 32-bit saturating increment used by the cycle counter
// ----------------------------------------------------------------------------
package top_chip_test_monitor_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } mon_state_e;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PASS    = 2'd1,
        RES_FAIL    = 2'd2,
        RES_TIMEOUT = 2'd3
    } mon_result_e;

    localparam logic [31:0] DefaultPassCode = 32'hDEADBEEF;
    localparam logic [31:0] DefaultFailCode = 32'hBAADF00D;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/top_chip_test_monitor_chan.sv
// ----------------------------------------------------------------------------
// top_chip_test_monitor_chan
// Watches one status word. Keeps the previous sample and two stability
// counters (pass code, fail code). An event fires combinationally on the edge
// at which the matching counter reaches StableCycles.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   count_en   : counters advance only while the monitor is running and enabled
//   status     : this channel's status word
//   pass_evt   : pass code held for StableCycles enabled samples (this edge)
//   fail_evt   : fail code held for StableCycles enabled samples (this edge)
//   changed    : current sample differs from the previous one
// ----------------------------------------------------------------------------
module top_chip_test_monitor_chan import top_chip_test_monitor_pkg::*; #(
    parameter int unsigned      Width        = 32,
    parameter int unsigned      StableCycles = 1,
    parameter logic [Width-1:0] PassWord     = Width'(DefaultPassCode),
    parameter logic [Width-1:0] FailWord     = Width'(DefaultFailCode)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             count_en,
    input  logic [Width-1:0] status,
    output logic             pass_evt,
    output logic             fail_evt,
    output logic             changed
);

    localparam int unsigned    CntW    = $clog2(StableCycles + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(StableCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(StableCycles - 1);

    logic [Width-1:0] prev;
    logic [CntW-1:0]  pass_cnt;
    logic [CntW-1:0]  fail_cnt;
    logic             pass_hit;
    logic             fail_hit;

    assign pass_hit = (status == PassWord);
    assign fail_hit = (status == FailWord);
    assign changed  = (status != prev);

    // The counter holds the number of earlier consecutive hits, so the edge
    // that completes the run is the one where it still reads StableCycles-1.
    assign pass_evt = count_en && pass_hit && (pass_cnt == CntLast);
    assign fail_evt = count_en && fail_hit && (fail_cnt == CntLast);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev     <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            // The previous sample tracks the bus even while disabled.
            prev <= status;

            if (count_en && pass_hit) begin
                if (pass_cnt != CntMax) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end else begin
                pass_cnt <= '0;
            end

            if (count_en && fail_hit) begin
                if (fail_cnt != CntMax) begin
                    fail_cnt <= fail_cnt + 1'b1;
                end
            end else begin
                fail_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/top_chip_test_monitor.sv
// ----------------------------------------------------------------------------
// top_chip_test_monitor
// End-of-test monitor for the top_chip benches. Classifies a run as pass,
// fail or inactivity timeout, then after a drain period issues a single-cycle
// finish request.
//
//   state | meaning
//   RUN   | watching channels, counting enabled cycles
//   DRAIN | result latched, counting DrainCycles before the finish request
//   DONE  | finish issued, everything frozen until reset
//
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   enable_i      : monitoring enable (only honoured in RUN)
//   status_i      : NumCh flat status words, channel c at [c*Width +: Width]
//   passed_o      : sticky pass flag
//   failed_o      : sticky fail flag
//   timed_out_o   : sticky inactivity timeout flag
//   result_ch_o   : channel that caused detection (0 for timeout)
//   finish_o      : one-cycle finish request
//   cycles_o      : enabled RUN cycles, frozen at detection, saturating
// ----------------------------------------------------------------------------
module top_chip_test_monitor import top_chip_test_monitor_pkg::*; #(
    parameter int unsigned Width         = 32,
    parameter int unsigned NumCh         = 1,
    parameter logic [31:0] PassCode      = DefaultPassCode,
    parameter logic [31:0] FailCode      = DefaultFailCode,
    parameter int unsigned StableCycles  = 1,
    parameter int unsigned DrainCycles   = 7,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        enable_i,
    input  logic [NumCh*Width-1:0]                      status_i,
    output logic                                        passed_o,
    output logic                                        failed_o,
    output logic                                        timed_out_o,
    output logic [((NumCh > 1) ? $clog2(NumCh) : 1)-1:0] result_ch_o,
    output logic                                        finish_o,
    output logic [31:0]                                 cycles_o
);

    localparam int unsigned     ChW         = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int unsigned     DrW         = (DrainCycles > 0) ? $clog2(DrainCycles + 1) : 1;
    localparam logic [DrW-1:0]  DrainLast   = DrW'(DrainCycles);
    localparam logic [31:0]     TimeoutLast = (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);
    localparam logic [Width-1:0] PassWord   = Width'(PassCode);
    localparam logic [Width-1:0] FailWord   = Width'(FailCode);

    mon_state_e     state;
    logic [DrW-1:0] drain_cnt;
    logic [31:0]    inact_cnt;
    logic           count_en;
    logic           any_changed;
    logic           timeout_evt;
    logic [NumCh-1:0] pass_evt;
    logic [NumCh-1:0] fail_evt;
    logic [NumCh-1:0] changed;
    mon_result_e    result;
    logic [ChW-1:0] result_ch;

    assign count_en    = (state == RUN) && enable_i;
    assign any_changed = |changed;
    assign timeout_evt = (TimeoutCycles != 0) && count_en && !any_changed
                         && (inact_cnt == TimeoutLast);

    for (genvar c = 0; c < NumCh; c++) begin : g_chan
        top_chip_test_monitor_chan #(
            .Width        (Width),
            .StableCycles (StableCycles),
            .PassWord     (PassWord),
            .FailWord     (FailWord)
        ) u_chan (
            .clk      (clk_i),
            .rst_n    (rst_ni),
            .count_en (count_en),
            .status   (status_i[c*Width +: Width]),
            .pass_evt (pass_evt[c]),
            .fail_evt (fail_evt[c]),
            .changed  (changed[c])
        );
    end

    // Priority fail > timeout > pass; each class is scanned from the top
    // channel down so the lowest index is the last (winning) assignment.
    always_comb begin
        result    = RES_NONE;
        result_ch = '0;
        for (int c = NumCh - 1; c >= 0; c--) begin
            if (pass_evt[c]) begin
                result    = RES_PASS;
                result_ch = ChW'(c);
            end
        end
        if (timeout_evt) begin
            result    = RES_TIMEOUT;
            result_ch = '0;
        end
        for (int c = NumCh - 1; c >= 0; c--) begin
            if (fail_evt[c]) begin
                result    = RES_FAIL;
                result_ch = ChW'(c);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= RUN;
            drain_cnt   <= '0;
            inact_cnt   <= '0;
            passed_o    <= 1'b0;
            failed_o    <= 1'b0;
            timed_out_o <= 1'b0;
            result_ch_o <= '0;
            finish_o    <= 1'b0;
            cycles_o    <= '0;
        end else begin
            finish_o <= 1'b0;
            case (state)
                RUN: begin
                    if (enable_i) begin
                        cycles_o  <= sat_inc32(cycles_o);
                        inact_cnt <= any_changed ? 32'd0 : sat_inc32(inact_cnt);
                    end else begin
                        inact_cnt <= '0;
                    end
                    if (result != RES_NONE) begin
                        passed_o    <= (result == RES_PASS);
                        failed_o    <= (result == RES_FAIL);
                        timed_out_o <= (result == RES_TIMEOUT);
                        result_ch_o <= result_ch;
                        drain_cnt   <= '0;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DrainLast) begin
                        finish_o <= 1'b1;
                        state    <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_chip_test_monitor.sv
// ----------------------------------------------------------------------------
// Bench for top_chip_test_monitor: two 16-bit channels, StableCycles=3,
// DrainCycles=4, TimeoutCycles=30. A behavioural model keeps the full sample
// history since reset and derives the outcome by looking back over it.
// ----------------------------------------------------------------------------
module tb_top_chip_test_monitor;

    localparam int unsigned W  = 16;
    localparam int unsigned NC = 2;
    localparam int unsigned S  = 3;
    localparam int unsigned D  = 4;
    localparam int unsigned T  = 30;
    localparam logic [15:0] PW = 16'hBEEF;
    localparam logic [15:0] FW = 16'hF00D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] status = '0;
    logic        passed;
    logic        failed;
    logic        timed_out;
    logic        result_ch;
    logic        finish;
    logic [31:0] cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    top_chip_test_monitor #(
        .Width         (W),
        .NumCh         (NC),
        .PassCode      (32'hDEADBEEF),
        .FailCode      (32'hBAADF00D),
        .StableCycles  (S),
        .DrainCycles   (D),
        .TimeoutCycles (T)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (en),
        .status_i    (status),
        .passed_o    (passed),
        .failed_o    (failed),
        .timed_out_o (timed_out),
        .result_ch_o (result_ch),
        .finish_o    (finish),
        .cycles_o    (cycles)
    );

    // ---------------- reference model ----------------
    logic [31:0] hs[$];
    bit          hen[$];
    int          phase;   // 0 watching, 1 draining, 2 finished
    int          n;       // non-reset edges since reset
    int          det;
    int          ncyc;
    bit          m_pass, m_fail, m_to, m_fin;
    int          m_ch;

    function automatic bit held(int c, logic [15:0] code);
        int L = hs.size();
        logic [31:0] t;
        if (L < int'(S)) return 1'b0;
        for (int i = L - int'(S); i < L; i++) begin
            t = hs[i];
            if (!hen[i] || t[c*16 +: 16] != code) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Trailing run of enabled edges on which no channel changed.
    function automatic int quiet();
        int k = 0;
        logic [31:0] p;
        for (int i = hs.size() - 1; i >= 0; i--) begin
            p = (i == 0) ? 32'd0 : hs[i-1];
            if (!hen[i] || hs[i] != p) break;
            k++;
        end
        return k;
    endfunction

    task automatic model_edge(bit r, bit e, logic [31:0] s);
        bit fire;
        if (!r) begin
            hs.delete();
            hen.delete();
            phase = 0; n = 0; det = 0; ncyc = 0;
            m_pass = 0; m_fail = 0; m_to = 0; m_fin = 0; m_ch = 0;
            return;
        end
        n++;
        m_fin = 0;
        if (phase == 0) begin
            hs.push_back(s);
            hen.push_back(e);
            if (e) ncyc++;
            fire = 0;
            for (int c = 0; c < int'(NC); c++)
                if (!fire && held(c, FW)) begin fire = 1; m_fail = 1; m_ch = c; end
            if (!fire && quiet() >= int'(T)) begin fire = 1; m_to = 1; m_ch = 0; end
            for (int c = 0; c < int'(NC); c++)
                if (!fire && held(c, PW)) begin fire = 1; m_pass = 1; m_ch = c; end
            if (fire) begin phase = 1; det = n; end
        end else if (phase == 1) begin
            if (n == det + int'(D) + 1) begin m_fin = 1; phase = 2; end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic step(bit r, bit e, logic [31:0] s);
        rst_n  = r;
        en     = e;
        status = s;
        @(posedge clk);
        #1;
        model_edge(r, e, s);
        chk("passed",    32'(passed),    32'(m_pass));
        chk("failed",    32'(failed),    32'(m_fail));
        chk("timed_out", 32'(timed_out), 32'(m_to));
        chk("result_ch", 32'(result_ch), 32'(m_ch));
        chk("finish",    32'(finish),    32'(m_fin));
        chk("cycles",    cycles,         32'(ncyc));
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        do w = 16'($urandom); while (w == PW || w == FW);
        return w;
    endfunction

    function automatic logic [31:0] noise();
        return {rnd_word(), rnd_word()};
    endfunction

    logic [15:0] cur [2];
    logic [15:0] pick;
    int          done_age;

    initial begin
        // Reset state
        step(0, 0, '0);
        step(0, 0, '0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);

        // Pass on ch0: a 2-edge pulse is ignored, a 3-edge hold detects
        for (int i = 0; i < 10; i++) step(1, 1, noise());
        step(1, 1, {rnd_word(), PW});
        step(1, 1, {rnd_word(), PW});
        step(1, 1, noise());
        step(1, 1, {rnd_word(), PW});
        step(1, 1, {rnd_word(), PW});
        chk("a_not_yet", 32'(passed), 32'd0);
        step(1, 1, {rnd_word(), PW});
        chk("a_passed", 32'(passed), 32'd1);
        chk("a_ch", 32'(result_ch), 32'd0);
        chk("a_cycles", cycles, 32'd16);
        for (int i = 1; i <= 7; i++) begin
            step(1, 1, {FW, FW});
            chk("a_finish_at", 32'(finish), 32'(i == 5));
        end
        chk("a_sticky_fail", 32'(failed), 32'd0);

        // Fail on ch1 beats simultaneous pass on ch0
        step(0, 1, '0);
        for (int i = 0; i < 3; i++) step(1, 1, {FW, PW});
        chk("b_failed", 32'(failed), 32'd1);
        chk("b_passed", 32'(passed), 32'd0);
        chk("b_ch", 32'(result_ch), 32'd1);
        for (int i = 0; i < 7; i++) step(1, 1, noise());

        // Timeout: change at edge 10, then again at edge 25 -> fires at 55
        step(0, 1, '0);
        for (int i = 1; i <= 9; i++) step(1, 1, {16'(i), 16'(i)});
        step(1, 1, 32'h1234_5678);
        for (int i = 11; i <= 24; i++) step(1, 1, 32'h1234_5678);
        chk("c_no_early_to", 32'(timed_out), 32'd0);
        step(1, 1, 32'h1234_5679);
        for (int i = 26; i <= 54; i++) step(1, 1, 32'h1234_5679);
        chk("c_to_edge54", 32'(timed_out), 32'd0);
        step(1, 1, 32'h1234_5679);
        chk("c_to_edge55", 32'(timed_out), 32'd1);
        chk("c_to_ch", 32'(result_ch), 32'd0);
        chk("c_to_cycles", cycles, 32'd55);
        for (int i = 0; i < 7; i++) step(1, 1, noise());

        // Enable low while pass code is held
        step(0, 0, '0);
        for (int i = 0; i < 6; i++) step(1, 0, {16'h0123, PW});
        chk("d_cycles_static", cycles, 32'd0);
        chk("d_no_detect", 32'(passed), 32'd0);
        step(1, 1, {16'h0123, PW});
        step(1, 1, {16'h0123, PW});
        chk("d_not_yet", 32'(passed), 32'd0);
        step(1, 1, {16'h0123, PW});
        chk("d_passed", 32'(passed), 32'd1);
        chk("d_cycles", cycles, 32'd3);
        for (int i = 0; i < 7; i++) step(1, 1, noise());

        // Reset in the middle of DRAIN, then redetect
        step(0, 1, '0);
        for (int i = 0; i < 3; i++) step(1, 1, {rnd_word(), PW});
        step(1, 1, noise());
        step(1, 1, noise());
        step(0, 1, {rnd_word(), PW});
        chk("e_rst_passed", 32'(passed), 32'd0);
        chk("e_rst_cycles", cycles, 32'd0);
        chk("e_rst_finish", 32'(finish), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 1, {rnd_word(), PW});
        chk("e_redetect", 32'(passed), 32'd1);
        for (int i = 0; i < 7; i++) step(1, 1, noise());

        // Randomised traffic against the model
        step(0, 1, '0);
        cur[0] = '0;
        cur[1] = '0;
        done_age = 0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < 2; c++) begin
                case ($urandom_range(0, 99)) inside
                    [0:39]:  pick = cur[c];
                    [40:64]: pick = PW;
                    [65:79]: pick = FW;
                    default: pick = rnd_word();
                endcase
                cur[c] = pick;
            end
            if (phase == 2) done_age++;
            if (done_age > 3 || $urandom_range(0, 99) == 0) begin
                done_age = 0;
                cur[0] = '0;
                cur[1] = '0;
                step(0, 1'($urandom_range(0, 1)), noise());
            end else begin
                step(1, ($urandom_range(0, 7) != 0), {cur[1], cur[0]});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
